// File: rtl/output_drain.sv
// ============================================================================
// Module   : output_drain
// Purpose  : Buffers systolic column results in a small FIFO and drains a
//            snapshot of them to the unified buffer through a ready/valid port.
// Options  : OUTPUT_DRAIN_OVF_FLAG_EN enables the sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_drain #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       col_valid_in,
  input  logic signed [15:0]         col_data_in,
  input  logic                       drain_start_in,
  input  logic [ADDR_W-1:0]          drain_base_addr_in,
  input  logic                       ub_wr_ready_in,
  output logic                       ub_wr_valid_out,
  output logic signed [15:0]         ub_wr_data_out,
  output logic [ADDR_W-1:0]          ub_wr_addr_out,
  output logic                       drain_busy_out,
  output logic                       drain_done_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       ovf_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic signed [15:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic signed [15:0] out_data_q;
  logic               out_valid_q;
  logic               done_q;

  logic w_full;
  logic w_enq;
  logic w_hs;
  logic w_pop;

  assign w_full = (count_q == CNT_W'(DEPTH));
  assign w_enq  = col_valid_in && !w_full;
  assign w_hs   = out_valid_q && ub_wr_ready_in;
  assign w_pop  = (state_q == ST_DRAIN) && (remaining_q != '0) && (!out_valid_q || w_hs);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain_start_in) state_d = (count_q != '0) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (w_hs && (remaining_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Storage is not reset: clearing the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (w_enq) mem_q[wr_ptr_q] <= col_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // The pulse follows the DONE state by one edge, so an empty drain
      // reports completion two cycles after the request, like the first write.
      done_q  <= (state_q == ST_DONE);
      if ((state_q == ST_IDLE) && drain_start_in) begin
        remaining_q <= count_q;
        addr_q      <= drain_base_addr_in;
      end
      if (w_pop) begin
        remaining_q <= remaining_q - 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[rd_ptr_q];
        out_addr_q  <= addr_q;
        addr_q      <= addr_q + 1'b1;
      end else if (w_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef OUTPUT_DRAIN_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (col_valid_in && w_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_out = ovf_q;
`else
  assign ovf_out = 1'b0;
`endif

  assign ub_wr_valid_out = out_valid_q;
  assign ub_wr_data_out  = out_data_q;
  assign ub_wr_addr_out  = out_addr_q;
  assign drain_busy_out  = (state_q == ST_DRAIN);
  assign drain_done_out  = done_q;
  assign count_out       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_output_drain.sv
// ============================================================================
// Module   : tb_output_drain
// Purpose  : Scoreboard bench for output_drain (DEPTH=4, ADDR_W=8); honours
//            OUTPUT_DRAIN_OVF_FLAG_EN for the expected overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_drain;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               col_valid_in;
  logic signed [15:0] col_data_in;
  logic               drain_start_in;
  logic [7:0]         drain_base_addr_in;
  logic               ub_wr_ready_in;
  logic               ub_wr_valid_out;
  logic signed [15:0] ub_wr_data_out;
  logic [7:0]         ub_wr_addr_out;
  logic               drain_busy_out;
  logic               drain_done_out;
  logic [2:0]         count_out;
  logic               ovf_out;

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] model_q [$];
  logic signed [15:0] exp_data [$];
  logic [7:0]         exp_addr [$];
  logic               exp_ovf;

  output_drain #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .col_valid_in      (col_valid_in),
    .col_data_in       (col_data_in),
    .drain_start_in    (drain_start_in),
    .drain_base_addr_in(drain_base_addr_in),
    .ub_wr_ready_in    (ub_wr_ready_in),
    .ub_wr_valid_out   (ub_wr_valid_out),
    .ub_wr_data_out    (ub_wr_data_out),
    .ub_wr_addr_out    (ub_wr_addr_out),
    .drain_busy_out    (drain_busy_out),
    .drain_done_out    (drain_done_out),
    .count_out         (count_out),
    .ovf_out           (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic signed [15:0] v);
    col_valid_in = 1'b1;
    col_data_in  = v;
    if (model_q.size() < DEPTH) begin
      model_q.push_back(v);
    end else begin
`ifdef OUTPUT_DRAIN_OVF_FLAG_EN
      exp_ovf = 1'b1;
`endif
    end
    cycle();
    col_valid_in = 1'b0;
  endtask

  task automatic run_drain(input logic [7:0] base, input int stall_at, input int stall_len,
                           input int enq_at, input logic signed [15:0] enq_val, input string name);
    int n, k, first_hs, last_hs, done_k, dones;
    logic pv, pr, rdy;
    logic signed [15:0] pd;
    logic [7:0] pa;
    n = model_q.size();
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(model_q.pop_front());
      exp_addr.push_back(base + 8'(i));
    end
    drain_start_in     = 1'b1;
    drain_base_addr_in = base;
    ub_wr_ready_in     = 1'b1;
    cycle();
    drain_start_in = 1'b0;
    checks++;
    if (ub_wr_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL %s early_valid: got %b expected 0", name, ub_wr_valid_out);
    end
    checks++;
    if (drain_busy_out !== (n > 0)) begin
      failures++;
      $display("FAIL %s busy_after_start: got %b expected %b", name, drain_busy_out, n > 0);
    end
    first_hs = -1; last_hs = -1; done_k = -1; dones = 0;
    pv = 1'b0; pr = 1'b1; pd = '0; pa = '0;
    k = 0;
    while (done_k < 0 && k < 40) begin
      rdy = !(k >= stall_at && k < stall_at + stall_len);
      ub_wr_ready_in = rdy;
      col_valid_in   = (k == enq_at);
      col_data_in    = enq_val;
      if (k == enq_at) model_q.push_back(enq_val);
      if (pv && !pr) begin
        checks++;
        if (ub_wr_valid_out !== 1'b1 || ub_wr_data_out !== pd || ub_wr_addr_out !== pa) begin
          failures++;
          $display("FAIL %s hold: got v=%b d=%0d a=%h expected v=1 d=%0d a=%h",
                   name, ub_wr_valid_out, ub_wr_data_out, ub_wr_addr_out, pd, pa);
        end
      end
      if (ub_wr_valid_out && rdy) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL %s extra_write: got a=%h d=%0d expected none", name, ub_wr_addr_out, ub_wr_data_out);
        end else begin
          logic signed [15:0] ed;
          logic [7:0] ea;
          ed = exp_data.pop_front();
          ea = exp_addr.pop_front();
          if (ub_wr_data_out !== ed || ub_wr_addr_out !== ea) begin
            failures++;
            $display("FAIL %s write: got a=%h d=%0d expected a=%h d=%0d",
                     name, ub_wr_addr_out, ub_wr_data_out, ea, ed);
          end
        end
        if (first_hs < 0) first_hs = k;
        last_hs = k;
      end
      if (drain_done_out) begin
        dones++;
        done_k = k;
      end
      pv = ub_wr_valid_out; pr = rdy; pd = ub_wr_data_out; pa = ub_wr_addr_out;
      cycle();
      k++;
    end
    col_valid_in   = 1'b0;
    ub_wr_ready_in = 1'b1;
    checks++;
    if (done_k < 0) begin
      failures++;
      $display("FAIL %s timeout: got no done in %0d cycles expected done", name, k);
    end
    checks++;
    if (drain_done_out !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: got %b expected 0 after pulse", name, drain_done_out);
    end
    checks++;
    if (exp_data.size() != 0) begin
      failures++;
      $display("FAIL %s missing_writes: got %0d left expected 0", name, exp_data.size());
      exp_data.delete();
      exp_addr.delete();
    end
    if (n > 0) begin
      checks++;
      if (first_hs != 1) begin
        failures++;
        $display("FAIL %s first_valid_cycle: got %0d expected 1", name, first_hs);
      end
      checks++;
      if (done_k != last_hs + 2) begin
        failures++;
        $display("FAIL %s done_cycle: got %0d expected %0d", name, done_k, last_hs + 2);
      end
      if (stall_len == 0) begin
        checks++;
        if (last_hs - first_hs != n - 1) begin
          failures++;
          $display("FAIL %s throughput: got span %0d expected %0d", name, last_hs - first_hs, n - 1);
        end
      end
    end else begin
      checks++;
      if (done_k != 1 || first_hs != -1) begin
        failures++;
        $display("FAIL %s empty_drain: got done_k=%0d hs=%0d expected done_k=1 hs=-1", name, done_k, first_hs);
      end
    end
    checks++;
    if (drain_busy_out !== 1'b0 || count_out !== 3'(model_q.size())) begin
      failures++;
      $display("FAIL %s end_state: got busy=%b count=%0d expected busy=0 count=%0d",
               name, drain_busy_out, count_out, model_q.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (ub_wr_valid_out !== 1'b0 || ub_wr_data_out !== 16'sd0 || ub_wr_addr_out !== 8'h00 ||
        drain_busy_out !== 1'b0 || drain_done_out !== 1'b0 || count_out !== 3'd0 || ovf_out !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs: got v=%b d=%0d a=%h busy=%b done=%b cnt=%0d ovf=%b expected all 0",
               name, ub_wr_valid_out, ub_wr_data_out, ub_wr_addr_out, drain_busy_out,
               drain_done_out, count_out, ovf_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    col_valid_in = 1'b0; col_data_in = '0; drain_start_in = 1'b0;
    drain_base_addr_in = '0; ub_wr_ready_in = 1'b1;
    exp_ovf = 1'b0;
    cycle();
    cycle();
    check_all_zero("reset");
    rst = 1'b0;
    cycle();
    check_all_zero("post_reset");
  endtask

  task automatic test_basic();
    enqueue(16'sd10);
    enqueue(-16'sd3);
    enqueue(16'sd7);
    checks++;
    if (count_out !== 3'd3) begin
      failures++;
      $display("FAIL basic_count: got %0d expected 3", count_out);
    end
    run_drain(8'h20, -1, 0, -1, '0, "basic");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      enqueue(16'(100 + i));
      if (i == 3) begin
        checks++;
        if (count_out !== 3'd4) begin
          failures++;
          $display("FAIL ovf_fourth_count: got %0d expected 4", count_out);
        end
      end
    end
    checks++;
    if (count_out !== 3'd4) begin
      failures++;
      $display("FAIL ovf_fifth_count: got %0d expected 4", count_out);
    end
    checks++;
    if (ovf_out !== exp_ovf) begin
      failures++;
      $display("FAIL ovf_flag: got %b expected %b", ovf_out, exp_ovf);
    end
    run_drain(8'h40, -1, 0, -1, '0, "ovf_drain");
    checks++;
    if (ovf_out !== exp_ovf) begin
      failures++;
      $display("FAIL ovf_sticky: got %b expected %b", ovf_out, exp_ovf);
    end
  endtask

  task automatic test_stall();
    enqueue(16'sd1234);
    enqueue(-16'sd42);
    run_drain(8'h60, 2, 3, -1, '0, "stall");
  endtask

  task automatic test_empty();
    run_drain(8'h10, -1, 0, -1, '0, "empty");
  endtask

  task automatic test_wrap();
    enqueue(16'sd11);
    enqueue(16'sd22);
    enqueue(16'sd33);
    run_drain(8'hFE, -1, 0, -1, '0, "wrap");
  endtask

  task automatic test_enq_during_drain();
    enqueue(-16'sd5);
    enqueue(16'sd6);
    enqueue(-16'sd7);
    run_drain(8'h80, -1, 0, 2, 16'sd99, "enq_during");
  endtask

  task automatic test_rst_mid();
    enqueue(16'sd8);
    enqueue(16'sd9);
    drain_start_in = 1'b1;
    drain_base_addr_in = 8'hA0;
    ub_wr_ready_in = 1'b0;
    cycle();
    drain_start_in = 1'b0;
    cycle();
    cycle();
    checks++;
    if (ub_wr_valid_out !== 1'b1 || drain_busy_out !== 1'b1 || ub_wr_data_out !== 16'sd99) begin
      failures++;
      $display("FAIL rst_mid_pre: got v=%b busy=%b d=%0d expected v=1 busy=1 d=99",
               ub_wr_valid_out, drain_busy_out, ub_wr_data_out);
    end
    rst = 1'b1;
    cycle();
    check_all_zero("rst_mid");
    rst = 1'b0;
    ub_wr_ready_in = 1'b1;
    model_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (drain_done_out !== 1'b0 || ub_wr_valid_out !== 1'b0 || drain_busy_out !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_after: got done=%b v=%b busy=%b expected 0",
                 drain_done_out, ub_wr_valid_out, drain_busy_out);
      end
    end
    check_all_zero("rst_mid_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_empty();
    test_wrap();
    test_enq_during_drain();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
